// File: rtl/sha512_msg_fifo_pkg.sv
// ---------------------------------------------------------------------------
// hmac512_pkg
//
// Shared types and constants for the SHA-512 message path.
//   sha_fifo_t    : one FIFO entry, 64-bit big-endian message word plus an
//                   8-bit byte mask. The FIFO ports carry the same layout as a
//                   flat vector: mask in [71:64], data in [63:0].
//   MsgFifoDepth  : default number of entries in the message FIFO.
//   MsgFifoWidth  : flat width of one entry.
//
// The optional statistics logic in sha512_msg_fifo is selected with the
// SHA512_MSG_FIFO_STATS_EN macro.
// ---------------------------------------------------------------------------
package hmac512_pkg;

    typedef struct packed {
        logic [7:0]  mask;
        logic [63:0] data;
    } sha_fifo_t;

    localparam int MsgFifoDepth = 16;
    localparam int MsgFifoWidth = $bits(sha_fifo_t);

endpackage

// File: rtl/sha512_msg_fifo_mem.sv
// ---------------------------------------------------------------------------
// sha512_msg_fifo_mem
//
// Depth x Width register array for the message FIFO. One synchronous write
// port and one asynchronous read port, so the FIFO head is visible in the
// same cycle its read address is presented (first-word fall-through).
// The array has no reset; the FIFO pointers decide which entries are valid.
//
// Ports:
//   clk_i    in  1            clock
//   we_i     in  1            write enable
//   waddr_i  in  log2(Depth)  write address
//   wdata_i  in  Width        write data
//   raddr_i  in  log2(Depth)  read address
//   rdata_o  out Width        read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module sha512_msg_fifo_mem #(
    parameter int Depth = 16,
    parameter int Width = 72
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sha512_msg_fifo.sv
// ---------------------------------------------------------------------------
// sha512_msg_fifo
//
// Synchronous message FIFO between the SHA-512 packer and the compression
// core. Entries are 72 bits: byte mask in [71:64], message word in [63:0].
// Valid/ready handshakes on both sides; first-word fall-through read.
// Cleared by clr_i (driven from ~sha_en), which discards same-cycle traffic.
//
// Optional feature: define SHA512_MSG_FIFO_STATS_EN to build the high-water
// mark and write-stall counter. Without it max_depth_o and stall_cnt_o are
// tied to zero and no statistics registers exist.
//
// Ports:
//   clk_i         in  1      clock
//   rst_i         in  1      synchronous active-high reset
//   clr_i         in  1      synchronous clear
//   wvalid_i      in  1      write request
//   wready_o      out 1      space available
//   wdata_mask_i  in  Width  entry to write
//   rvalid_o      out 1      entry available
//   rready_i      in  1      consumer accepts head entry
//   rdata_mask_o  out Width  head entry
//   depth_o       out PtrW   current occupancy
//   full_o        out 1      depth_o == Depth
//   empty_o       out 1      depth_o == 0
//   max_depth_o   out PtrW   high-water mark since reset/clear
//   stall_cnt_o   out 16     saturating count of write stall cycles
// ---------------------------------------------------------------------------
module sha512_msg_fifo
    import hmac512_pkg::*;
#(
    parameter int Depth = MsgFifoDepth,
    parameter int Width = MsgFifoWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     wvalid_i,
    output logic                     wready_o,
    input  logic [Width-1:0]         wdata_mask_i,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    output logic [Width-1:0]         rdata_mask_o,
    output logic [$clog2(Depth):0]   depth_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   max_depth_o,
    output logic [15:0]              stall_cnt_o
);

    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = AddrW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate counter.
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;

    logic push;
    logic pop;

    // Flags come only from registered pointers, so no input reaches an
    // output combinationally.
    assign full_o   = (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]) &&
                      (wptr_q[AddrW] != rptr_q[AddrW]);
    assign empty_o  = (wptr_q == rptr_q);
    assign wready_o = ~full_o;
    assign rvalid_o = ~empty_o;

    // Modular difference of the pointers is the occupancy, 0..Depth.
    assign depth_o = wptr_q - rptr_q;

    assign push = wvalid_i & wready_o;
    assign pop  = rvalid_o & rready_i;

    // Clear wins over any same-cycle push or pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // A write blocked by clear is suppressed so the array only changes when
    // the write pointer actually advances.
    sha512_msg_fifo_mem #(
        .Depth (Depth),
        .Width (Width)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push & ~clr_i),
        .waddr_i (wptr_q[AddrW-1:0]),
        .wdata_i (wdata_mask_i),
        .raddr_i (rptr_q[AddrW-1:0]),
        .rdata_o (rdata_mask_o)
    );

`ifdef SHA512_MSG_FIFO_STATS_EN

    logic [PtrW-1:0] depth_d;
    logic [PtrW-1:0] max_depth_q, max_depth_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;

    // The high-water mark follows the next occupancy, so it never lags
    // depth_o by a cycle.
    assign depth_d = wptr_d - rptr_d;

    always_comb begin
        max_depth_d = max_depth_q;
        stall_cnt_d = stall_cnt_q;
        if (clr_i) begin
            max_depth_d = '0;
            stall_cnt_d = '0;
        end else begin
            if (depth_d > max_depth_q) begin
                max_depth_d = depth_d;
            end
            if (wvalid_i && !wready_o && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            max_depth_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            max_depth_q <= max_depth_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign max_depth_o = max_depth_q;
    assign stall_cnt_o = stall_cnt_q;

`else

    assign max_depth_o = '0;
    assign stall_cnt_o = '0;

`endif

endmodule

// File: tb/tb_sha512_msg_fifo.sv
// ---------------------------------------------------------------------------
// tb_sha512_msg_fifo
//
// Directed bench for sha512_msg_fifo: reset, ordering, full/stall, concurrent
// push/pop with pointer wrap, clear, mid-transfer reset and high-water mark.
// A small queue model predicts head data and occupancy from the stimulus.
// ---------------------------------------------------------------------------
module tb_sha512_msg_fifo;

    localparam int Depth = 16;
    localparam int Width = 72;

`ifdef SHA512_MSG_FIFO_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             clr_i;
    logic             wvalid_i;
    logic             wready_o;
    logic [Width-1:0] wdata_mask_i;
    logic             rvalid_o;
    logic             rready_i;
    logic [Width-1:0] rdata_mask_o;
    logic [4:0]       depth_o;
    logic             full_o;
    logic             empty_o;
    logic [4:0]       max_depth_o;
    logic [15:0]      stall_cnt_o;

    int checkCount = 0;
    int passCount  = 0;

    logic [Width-1:0] modelQ[$];
    int               modelMax   = 0;
    int               modelStall = 0;

    always #5 clk_i = ~clk_i;

    sha512_msg_fifo #(
        .Depth (Depth),
        .Width (Width)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (clr_i),
        .wvalid_i     (wvalid_i),
        .wready_o     (wready_o),
        .wdata_mask_i (wdata_mask_i),
        .rvalid_o     (rvalid_o),
        .rready_i     (rready_i),
        .rdata_mask_o (rdata_mask_o),
        .depth_o      (depth_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .max_depth_o  (max_depth_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [Width-1:0] actual,
                               input logic [Width-1:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, advances the model, then waits for the edge
    // and settles 1 ns past it so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic wv, input logic [Width-1:0] wd,
                                 input logic rr, input logic cl);
        int sizeBefore;
        wvalid_i     = wv;
        wdata_mask_i = wd;
        rready_i     = rr;
        clr_i        = cl;
        sizeBefore   = modelQ.size();
        if (rr && sizeBefore > 0) begin
            checkOutput("pop_data", rdata_mask_o, modelQ[0]);
        end
        if (cl) begin
            modelQ.delete();
            modelMax   = 0;
            modelStall = 0;
        end else begin
            if (wv && sizeBefore == Depth && modelStall < 65535) begin
                modelStall++;
            end
            if (rr && sizeBefore > 0) begin
                void'(modelQ.pop_front());
            end
            if (wv && sizeBefore < Depth) begin
                modelQ.push_back(wd);
            end
            if (modelQ.size() > modelMax) begin
                modelMax = modelQ.size();
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [Width-1:0] statExp(input int v);
        return StatsEn ? Width'(v) : '0;
    endfunction

    initial begin
        logic [Width-1:0] v0;
        logic [Width-1:0] v1;
        logic [Width-1:0] v2;
        logic [Width-1:0] lost;

        rst_i        = 1'b1;
        clr_i        = 1'b0;
        wvalid_i     = 1'b0;
        rready_i     = 1'b0;
        wdata_mask_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        checkOutput("rst_empty",  Width'(empty_o),     72'd1);
        checkOutput("rst_wready", Width'(wready_o),    72'd1);
        checkOutput("rst_rvalid", Width'(rvalid_o),    72'd0);
        checkOutput("rst_depth",  Width'(depth_o),     72'd0);
        checkOutput("rst_full",   Width'(full_o),      72'd0);
        checkOutput("rst_max",    Width'(max_depth_o), 72'd0);
        checkOutput("rst_stall",  Width'(stall_cnt_o), 72'd0);

        // Ordering and first-push latency
        v0 = 72'h00_0000000000000001;
        v1 = 72'hFF_0123456789ABCDEF;
        v2 = 72'h0F_DEADBEEFCAFEF00D;
        applyStimulus(1'b1, v0, 1'b0, 1'b0);
        checkOutput("first_rvalid", Width'(rvalid_o), 72'd1);
        checkOutput("first_head",   rdata_mask_o,     v0);
        applyStimulus(1'b1, v1, 1'b0, 1'b0);
        applyStimulus(1'b1, v2, 1'b0, 1'b0);
        checkOutput("order_depth", Width'(depth_o), 72'd3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idleCycle();
        checkOutput("order_empty",  Width'(empty_o),  72'd1);
        checkOutput("order_rvalid", Width'(rvalid_o), 72'd0);

        // Fill to full, then stall a 17th write for 5 cycles
        for (int i = 0; i < Depth; i++) begin
            applyStimulus(1'b1, {8'(i), 64'hA5A5_0000_0000_0000 + 64'(i)}, 1'b0, 1'b0);
        end
        checkOutput("full_flag",   Width'(full_o),   72'd1);
        checkOutput("full_wready", Width'(wready_o), 72'd0);
        checkOutput("full_depth",  Width'(depth_o),  72'd16);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 72'hEE_BADBADBADBADBAD, 1'b0, 1'b0);
        end
        idleCycle();
        checkOutput("stall_depth", Width'(depth_o),     72'd16);
        checkOutput("stall_cnt",   Width'(stall_cnt_o), statExp(5));
        checkOutput("stall_model", Width'(stall_cnt_o), statExp(modelStall));
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        idleCycle();
        checkOutput("pop1_wready", Width'(wready_o), 72'd1);
        checkOutput("pop1_depth",  Width'(depth_o),  72'd15);
        checkOutput("pop1_head",   rdata_mask_o,     {8'd1, 64'hA5A5_0000_0000_0001});
        for (int i = 0; i < Depth - 1; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        idleCycle();
        checkOutput("drain_empty", Width'(empty_o), 72'd1);

        // Concurrent push/pop at depth 5 over 40 cycles (pointers wrap)
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, {8'hC0 | 8'(i), 64'h1000 + 64'(i)}, 1'b0, 1'b0);
        end
        checkOutput("conc_start", Width'(depth_o), 72'd5);
        for (int i = 5; i < 45; i++) begin
            applyStimulus(1'b1, {8'hC0 | 8'(i), 64'h1000 + 64'(i)}, 1'b1, 1'b0);
        end
        idleCycle();
        checkOutput("conc_depth", Width'(depth_o), 72'd5);
        checkOutput("conc_head",  rdata_mask_o,    {8'hC0 | 8'd40, 64'h1000 + 64'd40});
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        idleCycle();
        checkOutput("conc_empty", Width'(empty_o), 72'd1);

        // Clear at depth 7 together with a push and a pop
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, {8'h70, 64'h7000 + 64'(i)}, 1'b0, 1'b0);
        end
        checkOutput("clr_pre_depth", Width'(depth_o), 72'd7);
        lost = 72'h33_3333333333333333;
        applyStimulus(1'b1, lost, 1'b1, 1'b1);
        checkOutput("clr_depth",  Width'(depth_o),     72'd0);
        checkOutput("clr_empty",  Width'(empty_o),     72'd1);
        checkOutput("clr_rvalid", Width'(rvalid_o),    72'd0);
        checkOutput("clr_max",    Width'(max_depth_o), 72'd0);
        checkOutput("clr_stall",  Width'(stall_cnt_o), 72'd0);
        applyStimulus(1'b1, 72'h44_4444444444444444, 1'b0, 1'b0);
        checkOutput("clr_after_head",  rdata_mask_o,    72'h44_4444444444444444);
        checkOutput("clr_after_depth", Width'(depth_o), 72'd1);

        // Reset with a push in flight
        rst_i = 1'b1;
        applyStimulus(1'b1, 72'h55_5555555555555555, 1'b0, 1'b0);
        rst_i = 1'b0;
        modelQ.delete();
        modelMax   = 0;
        modelStall = 0;
        idleCycle();
        checkOutput("midrst_depth", Width'(depth_o),     72'd0);
        checkOutput("midrst_empty", Width'(empty_o),     72'd1);
        checkOutput("midrst_max",   Width'(max_depth_o), 72'd0);

        // High-water mark: fill to 9, drain to 2, fill to 4
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, {8'h90, 64'h9000 + 64'(i)}, 1'b0, 1'b0);
        end
        checkOutput("hw_depth9", Width'(depth_o), 72'd9);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("hw_depth2", Width'(depth_o), 72'd2);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, {8'h94, 64'h9400 + 64'(i)}, 1'b0, 1'b0);
        end
        idleCycle();
        checkOutput("hw_depth4", Width'(depth_o),     72'd4);
        checkOutput("hw_max",    Width'(max_depth_o), statExp(9));
        checkOutput("hw_model",  Width'(max_depth_o), statExp(modelMax));
        checkOutput("hw_head",   rdata_mask_o,        {8'h90, 64'h9007});
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        idleCycle();
        checkOutput("end_empty", Width'(empty_o), 72'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
